// File: rtl/rgbw_frame_ctrl.sv
// rgbw_frame_ctrl
// Frame-level controller that sits behind the SPI byte receiver.
// Each chip-select frame carries a header byte and then channel data bytes.
// Data bytes are written into shadow registers. All channels are copied
// together into ch_out when cs deasserts, so the PWM side never sees a
// partially updated colour.
//
// Header byte layout:
//   [7]   WR  : 1 = write frame
//   [6]   INC : 1 = advance the channel address after every data byte
//   [5:2] must be zero
//   [1:0] start channel address (taken modulo NUM_CH)

module rgbw_frame_ctrl #(
  parameter int NUM_CH   = 4,   // power of two, 2..4
  parameter int MAX_DATA = 16   // data bytes accepted per frame
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                rdy,
  input  logic [7:0]          data,
  output logic [NUM_CH*8-1:0] ch_out,
  output logic                update,
  output logic                frame_err,
  output logic                busy
);

  // Address width: one bit is enough for two channels, two bits for four.
  localparam int AW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  // The counter must be able to hold MAX_DATA itself, which means "full".
  localparam int CW = $clog2(MAX_DATA + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_SKIP,
    S_COMMIT
  } state_t;

  state_t          state;
  logic            rdy_q;
  logic            cs_q;
  logic [AW-1:0]   addr;
  logic            inc;
  logic [CW-1:0]   cnt;
  logic            ovf_seen;
  logic [7:0]      shadow [NUM_CH];

  logic            byte_stb;
  logic            cs_fall;
  logic            hdr_wr_ok;
  logic            hdr_nop;
  logic            room;
  logic            will_have_data;

  // Edge detection and header decode, all taken from the current inputs.
  always_comb begin
    byte_stb       = rdy & ~rdy_q;
    cs_fall        = cs_q & ~cs;
    hdr_wr_ok      = data[7] && (data[5:2] == 4'b0000);
    hdr_nop        = (data == 8'h00);
    room           = (cnt < CNT_MAX);
    // A byte that arrives in the same cycle as cs rising is still written,
    // so it has to be counted when deciding whether the frame commits.
    will_have_data = (cnt != '0) || (byte_stb && room);
  end

  assign busy = (state != S_IDLE);

  // Frame FSM, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow array is small and visible through ch_out after
      // the next commit, so it is reset like every other register here
      // instead of being left uninitialised.
      state     <= S_IDLE;
      rdy_q     <= 1'b0;
      // cs_q starts low so a frame that is already running when reset is
      // released is not seen as a new falling edge and is skipped.
      cs_q      <= 1'b0;
      addr      <= '0;
      inc       <= 1'b0;
      cnt       <= '0;
      ovf_seen  <= 1'b0;
      update    <= 1'b0;
      frame_err <= 1'b0;
      ch_out    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= 8'h00;
      end
    end else begin
      // NOTE: every assignment in this block is non-blocking, so all of the
      // reads below see the values from before this clock edge, and a later
      // assignment to the same register in this block takes precedence over
      // the pulse defaults set here.
      rdy_q     <= rdy;
      cs_q      <= cs;
      update    <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state <= S_HDR;
            // Channels the frame does not write keep their current values.
            for (int i = 0; i < NUM_CH; i++) begin
              shadow[i] <= ch_out[i*8 +: 8];
            end
          end
        end

        S_HDR: begin
          if (cs) begin
            // Empty frame, or a header that arrives together with cs rising.
            state <= S_IDLE;
          end else if (byte_stb) begin
            if (hdr_wr_ok) begin
              state    <= S_DATA;
              addr     <= data[AW-1:0];
              inc      <= data[6];
              cnt      <= '0;
              ovf_seen <= 1'b0;
            end else begin
              // A no-op header (0x00) is silent. Any other bad header
              // raises an error. In both cases the rest of the frame is
              // ignored.
              state     <= S_SKIP;
              frame_err <= ~hdr_nop;
            end
          end
        end

        S_DATA: begin
          if (byte_stb) begin
            if (room) begin
              shadow[addr] <= data;
              cnt          <= cnt + 1'b1;
              if (inc) begin
                // NUM_CH is a power of two, so the address wraps on its own.
                addr <= addr + 1'b1;
              end
            end else if (!ovf_seen) begin
              // Overflow is reported only once per frame. Extra bytes are
              // dropped.
              frame_err <= 1'b1;
              ovf_seen  <= 1'b1;
            end
          end
          if (cs) begin
            state <= will_have_data ? S_COMMIT : S_IDLE;
          end
        end

        S_SKIP: begin
          if (cs) begin
            state <= S_IDLE;
          end
        end

        S_COMMIT: begin
          // update is registered here, so it rises in the same cycle that
          // ch_out first shows the new values.
          for (int i = 0; i < NUM_CH; i++) begin
            ch_out[i*8 +: 8] <= shadow[i];
          end
          update <= 1'b1;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_frame_ctrl.sv
// tb_rgbw_frame_ctrl
// Directed frames with hand-computed channel values. A negedge monitor counts
// update and frame_err pulses and flags pulses wider than one clock, as well
// as any ch_out change that happens without update.

module tb_rgbw_frame_ctrl;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        cs    = 1'b1;
  logic        rdy   = 1'b0;
  logic [7:0]  data  = 8'h00;
  logic [31:0] ch_out;
  logic        update;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rgbw_frame_ctrl #(
    .NUM_CH   (4),
    .MAX_DATA (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .rdy       (rdy),
    .data      (data),
    .ch_out    (ch_out),
    .update    (update),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor.
  int          upd_cnt     = 0;
  int          err_cnt     = 0;
  int          width_viol  = 0;
  int          change_viol = 0;
  logic        upd_prev    = 1'b0;
  logic        err_prev    = 1'b0;
  logic [31:0] ch_prev     = 32'h0;

  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (update === 1'b1 && upd_prev === 1'b1) width_viol++;
    if (frame_err === 1'b1 && err_prev === 1'b1) width_viol++;
    if (reset === 1'b0 && ch_out !== ch_prev && update !== 1'b1) change_viol++;
    upd_prev = update;
    err_prev = frame_err;
    ch_prev  = ch_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // All stimulus changes on the falling edge.
  task automatic frame_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    data = b;
    rdy  = 1'b1;
    repeat (hold) @(negedge clk);
    rdy  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  int upd0;
  int err0;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_ch_out", ch_out, 32'h0);
    check("rst_update", {31'h0, update}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: write all four channels, then check the commit latency exactly.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    check("t1_busy", {31'h0, busy}, 32'h1);
    send_byte(8'hC0, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    check("t1_no_early_commit", ch_out, 32'h0);
    cs = 1'b1;
    @(negedge clk);
    check("t1_update_lat1", {31'h0, update}, 32'h0);
    @(negedge clk);
    check("t1_update_lat2", {31'h0, update}, 32'h1);
    check("t1_ch_out", ch_out, 32'h44332211);
    repeat (3) @(negedge clk);
    check("t1_busy_after", {31'h0, busy}, 32'h0);
    check("t1_updates", upd_cnt - upd0, 1);
    check("t1_errs", err_cnt - err0, 0);

    // T2: start at ch3 and wrap around to ch0.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'hC3, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    frame_end();
    check("t2_ch_out", ch_out, 32'hAA3322BB);
    check("t2_updates", upd_cnt - upd0, 1);

    // T3: INC=0, so the last write to ch1 is the one that sticks.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'h81, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    frame_end();
    check("t3_ch_out", ch_out, 32'hAA3303BB);
    check("t3_updates", upd_cnt - upd0, 1);
    check("t3_errs", err_cnt - err0, 0);

    // T4: bad header 0x20 gives an error, and the following bytes are ignored.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'h20, 1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    frame_end();
    check("t4_bad_ch_out", ch_out, 32'hAA3303BB);
    check("t4_bad_updates", upd_cnt - upd0, 0);
    check("t4_bad_errs", err_cnt - err0, 1);
    // A write header with a reserved bit set is also rejected.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'hC4, 1);
    send_byte(8'h99, 1);
    frame_end();
    check("t4_rsv_ch_out", ch_out, 32'hAA3303BB);
    check("t4_rsv_updates", upd_cnt - upd0, 0);
    check("t4_rsv_errs", err_cnt - err0, 1);
    // A NOP header is silent.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'h00, 1);
    send_byte(8'h77, 1);
    frame_end();
    check("t4_nop_ch_out", ch_out, 32'hAA3303BB);
    check("t4_nop_updates", upd_cnt - upd0, 0);
    check("t4_nop_errs", err_cnt - err0, 0);

    // T5: 17 data bytes 0x10..0x20. The first 16 land, and the last four
    // written are 0x1C..0x1F.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'hC0, 1);
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(8'h10 + i), 1);
    end
    frame_end();
    check("t5_ch_out", ch_out, 32'h1F1E1D1C);
    check("t5_updates", upd_cnt - upd0, 1);
    check("t5_errs", err_cnt - err0, 1);

    // T6: reset in the middle of a frame. Nothing commits and the rest of
    // the frame is skipped.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'hC0, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_ch_out", ch_out, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    check("t6_skip_busy", {31'h0, busy}, 32'h0);
    frame_end();
    check("t6_skip_ch_out", ch_out, 32'h0);
    check("t6_skip_updates", upd_cnt - upd0, 0);
    // The next full frame commits normally. rdy is held for two clocks and
    // must count as a single byte.
    upd0 = upd_cnt; err0 = err_cnt;
    frame_begin();
    send_byte(8'hC0, 2);
    send_byte(8'hA1, 2);
    send_byte(8'hB2, 2);
    send_byte(8'hC3, 2);
    send_byte(8'hD4, 2);
    frame_end();
    check("t6_ch_out", ch_out, 32'hD4C3B2A1);
    check("t6_updates", upd_cnt - upd0, 1);
    check("t6_errs", err_cnt - err0, 0);

    // Properties that hold over the whole run.
    check("pulse_width", width_viol, 0);
    check("ch_out_only_with_update", change_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
